// File: rtl/gated_dlatch_bank.sv
// gated_dlatch_bank: gated D-latch bank (NAND/NOR, positive/negative level) with clocked complement observer.
// Define DNLATCH_NOR_EN to build the negative-level NOR variant and include it in the err check.
module nand_dlatch (
  input  logic d,
  input  logic g,
  input  logic rst,
  output logic q,
  output logic qn
);
  logic s_n, r_n;
  assign s_n = ~(d & g);
  assign r_n = ~(~d & g);
  always_latch
    if (rst) q <= 1'b0;
    else if (!s_n) q <= 1'b1;
    else if (!r_n) q <= 1'b0;
  // rst_n on the Q_n side keeps the complement high through reset
  assign qn = ~(r_n & q & ~rst);
endmodule

module nor_dlatch (
  input  logic d,
  input  logic g,
  input  logic rst,
  output logic q,
  output logic qn
);
  logic s, r;
  assign s = ~(~d | ~g | rst);
  assign r = ~(d | ~g);
  always_latch
    if (rst | r) q <= 1'b0;
    else if (s) q <= 1'b1;
  assign qn = ~(s | q);
endmodule

module gated_dlatch_bank #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  output logic [WIDTH-1:0] Q_pnand,
  output logic [WIDTH-1:0] Q_pnand_n,
  output logic [WIDTH-1:0] Q_pnor,
  output logic [WIDTH-1:0] Q_pnor_n,
  output logic [WIDTH-1:0] Q_nnand,
  output logic [WIDTH-1:0] Q_nnand_n,
  output logic [WIDTH-1:0] Q_nnor,
  output logic [WIDTH-1:0] Q_nnor_n,
  output logic [WIDTH-1:0] snap,
  output logic             err
);
  logic en_n;
  logic [WIDTH-1:0] bad;
  assign en_n = ~en;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand_dlatch u_pnand (.d(D[i]), .g(en),   .rst(rst), .q(Q_pnand[i]), .qn(Q_pnand_n[i]));
    nor_dlatch  u_pnor  (.d(D[i]), .g(en),   .rst(rst), .q(Q_pnor[i]),  .qn(Q_pnor_n[i]));
    nand_dlatch u_nnand (.d(D[i]), .g(en_n), .rst(rst), .q(Q_nnand[i]), .qn(Q_nnand_n[i]));
`ifdef DNLATCH_NOR_EN
    nor_dlatch  u_nnor  (.d(D[i]), .g(en_n), .rst(rst), .q(Q_nnor[i]),  .qn(Q_nnor_n[i]));
`else
    assign Q_nnor[i]   = 1'b0;
    assign Q_nnor_n[i] = 1'b1;
`endif
  end
`ifdef DNLATCH_NOR_EN
  assign bad = ~(Q_pnand ^ Q_pnand_n) | ~(Q_pnor ^ Q_pnor_n) | ~(Q_nnand ^ Q_nnand_n) | ~(Q_nnor ^ Q_nnor_n);
`else
  assign bad = ~(Q_pnand ^ Q_pnand_n) | ~(Q_pnor ^ Q_pnor_n) | ~(Q_nnand ^ Q_nnand_n);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snap <= '0;
      err  <= 1'b0;
    end else begin
      snap <= Q_pnand;
      err  <= err | (|bad);
    end
endmodule

// File: tb/tb_gated_dlatch_bank.sv
// tb_gated_dlatch_bank: random (D,en) stimulus against a behavioural latch reference model.
module tb_gated_dlatch_bank;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q_pnand, Q_pnand_n, Q_pnor, Q_pnor_n, Q_nnand, Q_nnand_n, Q_nnor, Q_nnor_n, snap;
  logic err;
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] m_p = '0, m_n = '0, m_snap = '0;
  logic m_err = 1'b0;

  gated_dlatch_bank #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .D(D), .en(en),
    .Q_pnand(Q_pnand), .Q_pnand_n(Q_pnand_n), .Q_pnor(Q_pnor), .Q_pnor_n(Q_pnor_n),
    .Q_nnand(Q_nnand), .Q_nnand_n(Q_nnand_n), .Q_nnor(Q_nnor), .Q_nnor_n(Q_nnor_n),
    .snap(snap), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    m_snap <= rst ? '0 : m_p;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic upd();
    if (rst) begin
      m_p = '0;
      m_n = '0;
    end else begin
      if (en) m_p = D;
      if (!en) m_n = D;
    end
  endtask

  task automatic check_all();
    chk("pnand", Q_pnand, m_p);
    chk("pnand_n", Q_pnand_n, ~m_p);
    chk("pnor", Q_pnor, m_p);
    chk("pnor_n", Q_pnor_n, ~m_p);
    chk("nnand", Q_nnand, m_n);
    chk("nnand_n", Q_nnand_n, ~m_n);
`ifdef DNLATCH_NOR_EN
    chk("nnor", Q_nnor, m_n);
    chk("nnor_n", Q_nnor_n, ~m_n);
`else
    chk("nnor", Q_nnor, '0);
    chk("nnor_n", Q_nnor_n, '1);
`endif
    chk("err", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, m_err});
  endtask

  task automatic step(input logic e, input logic [W-1:0] d);
    @(negedge clk);
    chk("snap", snap, m_snap);
    en = e;
    #1 upd();
    D = d;
    #1 upd();
    check_all();
  endtask

  initial begin
    #1 rst = 1'b1;
    D = '1;
    en = 1'b1;
    upd();
    #2;
    check_all();
    chk("snap_rst", snap, '0);
    @(negedge clk);
    rst = 1'b0;
    upd();
    #1 check_all();
    step(1'b1, '1);
    step(1'b0, '1);
    step(1'b0, '0);
    step(1'b0, 4'b1011);
    step(1'b1, 4'b1011);
    step(1'b1, '0);
    for (int k = 0; k < 16; k++)
      step(1'(($urandom >> 3) & 1), W'($urandom));
    step(1'b1, '1);
    step(1'b0, '1);
    step(1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    upd();
    #1 check_all();
    #2 rst = 1'b0;
    upd();
    #1 check_all();
    step(1'b1, 4'b0110);
    @(negedge clk);
    force dut.Q_pnand_n = {W{1'b1}};
    @(posedge clk);
    #1;
    release dut.Q_pnand_n;
    m_err = 1'b1;
    chk("err_set", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, 1'b1});
    step(1'b1, 4'b1001);
    step(1'b0, 4'b0101);
    step(1'b1, 4'b1100);
    @(negedge clk);
    rst = 1'b1;
    m_err = 1'b0;
    upd();
    #1 check_all();
    chk("snap_rst2", snap, '0);
    rst = 1'b0;
    upd();
    step(1'b0, 4'b0011);
    step(1'b1, 4'b1111);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
